timer_seq: RTL and testbench

TIMER_SEQ -- requirements
Module: timer_seq

---
 rtl/timer_pkg.sv | 28 ++
 rtl/timer_seq_apb.sv | 60 ++++++
 rtl/timer_seq.sv | 92 +++++++++
 tb/tb_timer_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: timer register map, STATUS fields and state encodings shared by sequencer and benches
package timer_pkg;
  localparam int ADDR_STATUS = 0;
  localparam int ADDR_GOAL = 1;
  localparam int ADDR_CURR = 2;
  localparam int STATUS_START = 0;
  localparam int STATUS_STOP = 1;
  localparam int STATUS_STATE_LSB = 2;
  typedef enum logic [1:0] {
    TMR_IDLE = 2'd0,
    TMR_RUNNING = 2'd1,
    TMR_COMPLETE = 2'd2
  } tmr_state_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_POLL,
    S_GAP,
    S_STOP,
    S_REPORT
  } seq_state_e;
  typedef enum logic [1:0] {
    PH_IDLE,
    PH_ACCESS,
    PH_TAIL
  } apb_phase_e;
endpackage

// File: rtl/timer_seq_apb.sv
// apb_master_port: one APB transfer per start (SETUP, ACCESS until pready, one psel=0 tail cycle)
module apb_master_port
  import timer_pkg::*;
#(
  parameter int AW = 2,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          write,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic [DW-1:0] rdata,
  output logic          slverr,
  output logic          ack,
  output logic [AW-1:0] paddr,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [DW-1:0] pwdata,
  input  logic [DW-1:0] prdata,
  input  logic          pready,
  input  logic          pslverr
);
  apb_phase_e phase_q, phase_d;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q;
  logic write_q, slverr_q, setup, fin;
  // SETUP is the idle phase with start raised, so a transfer begins the cycle start appears
  assign setup = phase_q == PH_IDLE && start;
  assign fin = phase_q == PH_ACCESS && pready;
  // phase sequencing: SETUP -> ACCESS (held until pready) -> TAIL -> idle
  always_comb phase_d = setup ? PH_ACCESS : fin ? PH_TAIL : phase_q == PH_TAIL ? PH_IDLE : phase_q;
  // phase register; request captured at SETUP, response captured on the completing ACCESS
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      slverr_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      if (setup) {addr_q, write_q, wdata_q} <= {addr, write, wdata};
      if (fin) {rdata_q, slverr_q} <= {prdata, pslverr};
    end
  end
  assign psel = setup || phase_q == PH_ACCESS;
  assign penable = phase_q == PH_ACCESS;
  assign paddr = setup ? addr : addr_q;
  assign pwrite = setup ? write : write_q;
  assign pwdata = setup ? wdata : wdata_q;
  assign busy = phase_q != PH_IDLE;
  assign ack = phase_q == PH_TAIL;
  assign rdata = rdata_q;
  assign slverr = slverr_q;
endmodule

// File: rtl/timer_seq.sv
// timer_seq: runs timer jobs over APB (GOAL write, START, STATUS polling); TIMER_SEQ_TIMEOUT_EN adds a 255-poll timeout
module timer_seq
  import timer_pkg::*;
#(
  parameter int addrWidth = 2,
  parameter int dataWidth = 8,
  parameter int pollGap = 4
) (
  input  logic                 clk,
  input  logic                 preset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [dataWidth-1:0] req_goal,
  input  logic                 abort,
  output logic                 done,
  output logic                 err,
  output logic [addrWidth-1:0] paddr,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [dataWidth-1:0] pwdata,
  input  logic [dataWidth-1:0] prdata,
  input  logic                 pready,
  input  logic                 pslverr
);
  seq_state_e state_q, state_d;
  logic [dataWidth-1:0] goal_q, wdata, rdata;
  logic [addrWidth-1:0] addr;
  logic [7:0] gap_q;
  logic abort_q, err_q, start, write, busy, ack, slverr, complete, timeout, abort_pend, run, unused_rdata;
  assign run = state_q inside {S_LOAD, S_START, S_POLL, S_GAP};
  assign abort_pend = abort_q || abort;
  assign complete = rdata[STATUS_STATE_LSB +: 2] == TMR_COMPLETE;
  assign unused_rdata = ^rdata;
  apb_master_port #(.AW(addrWidth), .DW(dataWidth)) u_apb (
    .clk(clk), .rst(preset), .start(start), .write(write), .addr(addr), .wdata(wdata),
    .busy(busy), .rdata(rdata), .slverr(slverr), .ack(ack),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );
`ifdef TIMER_SEQ_TIMEOUT_EN
  logic [7:0] polls_q;
  // count finished polls of the running job; the 255th without COMPLETE times out
  always_ff @(posedge clk) begin
    if (preset || state_q == S_IDLE) polls_q <= '0;
    else if (state_q == S_POLL && ack) polls_q <= polls_q + 8'd1;
  end
  assign timeout = !complete && polls_q == 8'd254;
`else
  assign timeout = 1'b0;
`endif
  // state register plus job context (goal, gap counter, pending abort, failure flag)
  always_ff @(posedge clk) begin
    if (preset) begin
      state_q <= S_IDLE;
      goal_q <= '0;
      gap_q <= '0;
      abort_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req_valid) goal_q <= req_goal;
      gap_q <= state_q == S_GAP ? gap_q + 8'd1 : 8'd0;
      abort_q <= run && abort_pend;
      if (state_q == S_IDLE) err_q <= 1'b0;
      else if ((ack && slverr) || state_d == S_STOP) err_q <= 1'b1;
    end
  end
  // next state: each transfer state advances when its tail cycle (ack) is reached
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = req_valid ? S_LOAD : S_IDLE;
      S_LOAD: if (ack) state_d = slverr ? S_REPORT : abort_pend ? S_STOP : S_START;
      S_START: if (ack) state_d = slverr ? S_REPORT : abort_pend ? S_STOP : S_POLL;
      S_POLL: if (ack) state_d = slverr ? S_REPORT : (abort_pend || timeout) ? S_STOP : complete ? S_REPORT : pollGap == 0 ? S_POLL : S_GAP;
      S_GAP: state_d = abort_pend ? S_STOP : gap_q == 8'(pollGap - 1) ? S_POLL : S_GAP;
      S_STOP: if (ack) state_d = S_REPORT;
      default: state_d = S_IDLE;
    endcase
  end
  // outputs and the transfer request presented to the APB port for the current state
  always_comb begin
    req_ready = state_q == S_IDLE;
    done = state_q == S_REPORT;
    err = done && err_q;
    start = state_q inside {S_LOAD, S_START, S_POLL, S_STOP} && !busy;
    write = state_q != S_POLL;
    addr = state_q == S_LOAD ? addrWidth'(ADDR_GOAL) : addrWidth'(ADDR_STATUS);
    wdata = state_q == S_LOAD ? goal_q : state_q == S_STOP ? dataWidth'(1 << STATUS_STOP) : dataWidth'(1 << STATUS_START);
  end
endmodule

// File: tb/tb_timer_seq.sv
// tb_timer_seq: scoreboard bench for timer_seq with a behavioural APB timer (TIMER_SEQ_TIMEOUT_EN adds the timeout case)
module tb_timer_seq;
  localparam int GAP = 4;
  typedef struct packed {logic w; logic [1:0] a; logic [7:0] d;} xfer_t;
  logic clk = 1'b0, preset = 1'b1, req_valid = 1'b0, abort = 1'b0;
  logic [7:0] req_goal = '0, prdata = '0;
  logic pready = 1'b0, pslverr = 1'b0;
  logic req_ready, done, err, psel, penable, pwrite;
  logic [1:0] paddr;
  logic [7:0] pwdata;
  xfer_t exp_q[$];
  logic done_q[$];
  int n_chk = 0, n_err = 0, cyc = 0;
  int complete_on = 1, wait_n = 0, err_idx = -1, poll_cnt = 0, xfer_idx = 0;
  int done_cnt = 0, done_cyc = 0, acc_cyc = 0, ack_cyc = 0, last_poll = 0;
  timer_seq #(.addrWidth(2), .dataWidth(8), .pollGap(GAP)) dut (
    .clk(clk), .preset(preset), .req_valid(req_valid), .req_ready(req_ready), .req_goal(req_goal),
    .abort(abort), .done(done), .err(err), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask
  task automatic push_x(input logic w, input logic [1:0] a, input logic [7:0] d);
    exp_q.push_back('{w: w, a: a, d: d});
  endtask
  task automatic cfg(input int c, input int w, input int e);
    complete_on = c;
    wait_n = w;
    err_idx = e;
    poll_cnt = 0;
    xfer_idx = 0;
  endtask
  // expectations for a job that ends on COMPLETE after c polls
  task automatic push_norm(input logic [7:0] g, input int c);
    push_x(1'b1, 2'd1, g);
    push_x(1'b1, 2'd0, 8'h01);
    repeat (c) push_x(1'b0, 2'd0, 8'h00);
    done_q.push_back(1'b0);
  endtask
  task automatic start_job(input logic [7:0] g);
    int t = 0;
    while (!req_ready && t < 100) begin @(posedge clk); #1; t++; end
    req_valid = 1'b1;
    req_goal = g;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask
  task automatic wait_done();
    int n0 = done_cnt;
    int t = 0;
    while (done_cnt == n0 && t < 5000) begin @(posedge clk); #1; t++; end
    chk("done_seen", 32'(done_cnt - n0), 32'd1);
  endtask
  // behavioural timer slave plus protocol and scoreboard checks, once per cycle mid-period
  initial begin
    xfer_t e;
    int acc = 0;
    bit in_acc = 0, tail = 0;
    logic [1:0] s_addr = '0;
    logic [7:0] s_wdata = '0;
    logic s_write = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      pready = 1'b0;
      pslverr = 1'b0;
      if (preset) begin
        in_acc = 0;
        tail = 0;
        continue;
      end
      if (req_valid && req_ready) acc_cyc = cyc;
      if (tail) begin
        chk("tail_psel", 32'(psel), 32'd0);
        tail = 0;
      end
      if (psel && !penable) begin
        if (in_acc) chk("penable_held", 32'(penable), 32'd1);
        {s_addr, s_wdata, s_write} = {paddr, pwdata, pwrite};
        acc = 0;
        in_acc = 1;
        if (!pwrite && paddr == 2'd0) begin
          poll_cnt++;
          if (poll_cnt > 1 && wait_n == 0) chk("poll_spacing", 32'(cyc - last_poll), 32'(3 + GAP));
          last_poll = cyc;
        end
      end else if (psel && penable) begin
        chk("acc_addr", 32'(paddr), 32'(s_addr));
        chk("acc_wdata", 32'(pwdata), 32'(s_wdata));
        chk("acc_write", 32'(pwrite), 32'(s_write));
        pready = acc >= wait_n;
        acc++;
        if (pready) begin
          pslverr = xfer_idx == err_idx;
          prdata = poll_cnt >= complete_on ? 8'h08 : 8'h04;
          if (exp_q.size() == 0) chk("extra_xfer", 32'(paddr), 32'hdead);
          else begin
            e = exp_q.pop_front();
            chk("xfer_write", 32'(pwrite), 32'(e.w));
            chk("xfer_addr", 32'(paddr), 32'(e.a));
            if (e.w) chk("xfer_wdata", 32'(pwdata), 32'(e.d));
          end
          xfer_idx++;
          ack_cyc = cyc;
          in_acc = 0;
          tail = 1;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (done_q.size() == 0) chk("extra_done", 32'(done), 32'd0);
        else chk("done_err", 32'(err), 32'(done_q.pop_front()));
      end else chk("err_idle", 32'(err), 32'd0);
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 preset = 1'b0;
    chk("rst_psel", 32'(psel), 32'd0);
    chk("rst_penable", 32'(penable), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_pwdata", 32'(pwdata), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    // single poll job: acceptance to done is 10 cycles
    cfg(1, 0, -1);
    push_norm(8'd7, 1);
    start_job(8'd7);
    wait_done();
    chk("latency", 32'(done_cyc - acc_cyc), 32'd10);
    // goal 25, COMPLETE on the third poll
    cfg(3, 0, -1);
    push_norm(8'd25, 3);
    start_job(8'd25);
    wait_done();
    chk("ready_after", 32'(req_ready), 32'd1);
    // goal 0 runs the normal sequence
    cfg(2, 0, -1);
    push_norm(8'd0, 2);
    start_job(8'd0);
    wait_done();
    // three wait states on every transfer
    cfg(2, 3, -1);
    push_norm(8'h5a, 2);
    start_job(8'h5a);
    wait_done();
    // pslverr on the GOAL write ends the job without further transfers
    cfg(1, 0, 0);
    push_x(1'b1, 2'd1, 8'h33);
    done_q.push_back(1'b1);
    start_job(8'h33);
    wait_done();
    chk("slverr_delay", 32'(done_cyc - ack_cyc), 32'd2);
    // abort in the gap after the second poll
    cfg(1000, 0, -1);
    push_x(1'b1, 2'd1, 8'h44);
    push_x(1'b1, 2'd0, 8'h01);
    push_x(1'b0, 2'd0, 8'h00);
    push_x(1'b0, 2'd0, 8'h00);
    start_job(8'h44);
    for (int t = 0; t < 200 && xfer_idx < 4; t++) begin @(posedge clk); #1; end
    chk("abort_reach_gap", 32'(xfer_idx), 32'd4);
    @(posedge clk); #1;
    abort = 1'b1;
    push_x(1'b1, 2'd0, 8'h02);
    done_q.push_back(1'b1);
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done();
    chk("abort_ready", 32'(req_ready), 32'd1);
    // abort raised while idle has no effect on the next job
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    cfg(1, 0, -1);
    push_norm(8'h11, 1);
    start_job(8'h11);
    wait_done();
    // reset in the middle of an ACCESS cycle
    cfg(1, 3, -1);
    start_job(8'h66);
    for (int t = 0; t < 20 && !(psel && penable); t++) begin @(posedge clk); #1; end
    chk("rst_in_access", 32'(psel && penable), 32'd1);
    preset = 1'b1;
    @(posedge clk); #1;
    preset = 1'b0;
    exp_q.delete();
    chk("mid_rst_psel", 32'(psel), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    cfg(2, 0, -1);
    push_norm(8'h77, 2);
    start_job(8'h77);
    wait_done();
`ifdef TIMER_SEQ_TIMEOUT_EN
    // timer never completes: 255 polls then STOP and a failed done
    cfg(100000, 0, -1);
    push_x(1'b1, 2'd1, 8'h09);
    push_x(1'b1, 2'd0, 8'h01);
    repeat (255) push_x(1'b0, 2'd0, 8'h00);
    push_x(1'b1, 2'd0, 8'h02);
    done_q.push_back(1'b1);
    start_job(8'h09);
    wait_done();
    chk("timeout_polls", 32'(poll_cnt), 32'd255);
`endif
    repeat (3) @(posedge clk);
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
    chk("done_drained", 32'(done_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
